// File: rtl/tdc_hit_stamper_pkg.sv
// Shared widths and FSM encodings for the TDC hit stamper, encoder and readout.
package tdc_hit_stamper_pkg;

  localparam int TDC_FINE_WIDTH   = 4;
  localparam int TDC_COARSE_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DEAD    = 2'd2
  } tdc_state_t;

endpackage

// File: rtl/tdc_ts_fifo.sv
// Synchronous first-word-fall-through FIFO with level and full/empty flags.
// A push while full is accepted only when a pop frees the head slot in the
// same cycle; otherwise the push is ignored and the caller flags the drop.
module tdc_ts_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];
  assign level   = count;

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tdc_hit_stamper.sv
// Hit detection, coarse time base and timestamp buffering for the TDC chain.
// A fresh rising edge of hit_flag latches the coarse count, opens the encoder
// for one CAPTURE cycle, queues {coarse, fine} and then ignores edges for
// DEAD_CYCLES cycles.
module tdc_hit_stamper
  import tdc_hit_stamper_pkg::*;
#(
  parameter int COARSE_WIDTH = TDC_COARSE_WIDTH,
  parameter int FINE_WIDTH   = TDC_FINE_WIDTH,
  parameter int FIFO_DEPTH   = 8,
  parameter int DEAD_CYCLES  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic                             hit_flag,
  input  logic [FINE_WIDTH-1:0]            fine_bin,
  output logic                             enc_enable,
  output logic [COARSE_WIDTH+FINE_WIDTH-1:0] ts_data,
  output logic                             ts_valid,
  input  logic                             ts_ready,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic                             overflow,
  input  logic                             clear_ovf
);

  localparam int CNT_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  tdc_state_t              state;
  tdc_state_t              state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [COARSE_WIDTH-1:0] coarse;
  logic [COARSE_WIDTH-1:0] coarse_cap;
  logic                    hit_prev;
  logic                    hit_edge;
  logic                    cap_load;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    drop;

  assign hit_edge = hit_flag & ~hit_prev;
  assign ts_valid = ~fifo_empty;
  assign pop      = ts_valid & ts_ready;
  assign drop     = push & fifo_full & ~pop;

  // Free-running coarse counter, held at zero while the block is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          coarse <= '0;
    else if (!enable) coarse <= '0;
    else              coarse <= coarse + 1'b1;
  end

  // Previous hit sample for rising-edge detection, tracked in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hit_prev <= 1'b0;
    else     hit_prev <= hit_flag;
  end

  // Coarse time of the accepted edge, held until CAPTURE pushes it.
  always_ff @(posedge clk) begin
    if (cap_load) coarse_cap <= coarse;
  end

  // FSM state and dead-time counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and CAPTURE outputs; disabling forces IDLE but lets a CAPTURE push.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cap_load   = 1'b0;
    enc_enable = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (hit_edge && enable) begin
          cap_load  = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        enc_enable = 1'b1;
        push       = 1'b1;
        cnt_nxt    = CNT_W'(DEAD_CYCLES - 1);
        state_nxt  = DEAD;
      end
      DEAD: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
  end

  // Sticky overflow; a drop in the same cycle outranks the clear request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

  tdc_ts_fifo #(
    .WIDTH (COARSE_WIDTH + FINE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({coarse_cap, fine_bin}),
    .rdata (ts_data),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: doc/tdc_hit_stamper.md
Name: tdc_hit_stamper

Overview:
Downstream stage of the 16-bit thermometer-to-4-bit binary encoder in the TDC chain. Detects a hit from the synchronised delay-line sample and runs a free-running coarse counter. It gates the encoder's enable for exactly one capture cycle and concatenates coarse count with the encoder's fine code into a timestamp. Timestamps are buffered in a small first-word-fall-through FIFO and drained over a valid/ready handshake toward the readout logic.

Parameters:
COARSE_WIDTH, 12, width of free-running coarse counter (bits)
FINE_WIDTH, 4, width of fine code from encoder; fixed at 4 for the 16-tap line
FIFO_DEPTH, 8, timestamp FIFO entries; power of two, >= 2
DEAD_CYCLES, 2, clock cycles after a capture during which new hit edges are ignored; >= 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
enable  input  1  block enable; low = counter cleared, FSM held in IDLE
hit_flag  input  1  synchronised hit indicator (OR of sampled delay-line taps), clk domain
fine_bin  input  FINE_WIDTH  binary fine code from the encoder
enc_enable  output  1  drives encoder enable; high only in CAPTURE
ts_data  output  COARSE_WIDTH+FINE_WIDTH  {coarse, fine} timestamp at FIFO head
ts_valid  output  1  FIFO not empty
ts_ready  input  1  consumer accepts ts_data when ts_valid & ts_ready
fifo_level  output  $clog2(FIFO_DEPTH)+1  current number of stored entries
overflow  output  1  sticky: a timestamp was dropped because the FIFO was full
clear_ovf  input  1  synchronous clear of overflow

Behaviour:
- Reset (async, rst=1): coarse=0, FSM=IDLE, hit_prev=0, FIFO empty (pointers 0), enc_enable=0, ts_valid=0, ts_data=0, fifo_level=0, overflow=0.
- Coarse counter: +1 every cycle while enable=1; wraps 2^COARSE_WIDTH-1 -> 0 with no flag. enable=0: synchronous clear to 0.
- Edge detect: hit_prev <= hit_flag every cycle regardless of state; edge = hit_flag & ~hit_prev.
- FSM states: IDLE, CAPTURE, DEAD. All are registered.
  IDLE: edge & enable -> latch coarse_cap <= current coarse; go CAPTURE.
  CAPTURE (1 cycle): enc_enable=1; push {coarse_cap, fine_bin} into FIFO; go DEAD (cnt=DEAD_CYCLES-1).
  DEAD: decrement cnt; at 0 go IDLE. Edges here are discarded, not queued.
- enable=0 in any state: FSM forced to IDLE next cycle; a CAPTURE in progress that cycle still completes its push. FIFO contents are retained.
- A hit_flag held high across DEAD generates no second capture; a new capture needs a fresh 0->1 transition.
- Latency: edge at cycle N -> enc_enable high in cycle N+1 -> entry visible at ts_valid/ts_data in cycle N+2 (FIFO previously empty).
- FIFO: FWFT; ts_data = head entry; ts_data=0 when empty.
  Pop = ts_valid & ts_ready. Pop while empty is ignored.
  Push while full with no pop: entry dropped, overflow<=1.
  Push while full with simultaneous pop: both happen, no overflow, level unchanged.
  Simultaneous push and pop at other levels: level unchanged.
- overflow: set has priority over clear_ovf in the same cycle.
- Widths: ts_data MSBs = coarse_cap, LSBs = fine_bin. No arithmetic on the fine code.

Decomposition:
- Shared package/header: FINE_WIDTH=4, default COARSE_WIDTH and the FSM state encodings (IDLE=2'd0, CAPTURE=2'd1, DEAD=2'd2), so the encoder and readout agree on widths.
- One sub-module: tdc_ts_fifo, a parameterised synchronous FWFT FIFO (width, depth) with level and full/empty. The FSM, counter and edge detect stay in the top.

Test Plan:
- Reset mid-operation: rst pulsed during CAPTURE with 3 entries stored -> all outputs 0 immediately, FIFO empty, no entry pushed.
- Single hit: enable=1, coarse reaches 0x005, hit_flag rises, fine_bin=9 -> enc_enable high one cycle later. Two cycles after the edge: ts_valid=1, ts_data=0x0059, fifo_level=1; ts_ready=1 pops and drops ts_valid.
- Dead time: DEAD_CYCLES=2; hit_flag toggles 0->1->0->1 on consecutive cycles -> exactly one entry. An edge arriving after DEAD ends produces a second entry.
- Coarse wrap: hit at coarse=0xFFF and another at 0x001 -> entries 0xFFFx then 0x001x, with no extra flags.
- Overflow: ts_ready=0, 9 spaced hits with FIFO_DEPTH=8 -> level 8, 9th dropped, overflow=1. clear_ovf clears it, unless a drop occurs in the same cycle, which keeps it set.
- Full with simultaneous push and pop: FIFO full, ts_ready=1 in the CAPTURE cycle -> no overflow, level stays 8, head advances to the 2nd entry.
